// File: rtl/uart_stim_pkg.sv
// rtl/uart_stim_pkg.sv - shared state type, parity codes and frame sizing for the UART stimulus transmitter
package uart_stim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Serial bits per frame; multiply by CLKS_PER_BIT for the frame length in clocks.
  function automatic int frame_len(input int parity, input int stop_bits);
    return 1 + 8 + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_stim_fifo.sv
// rtl/uart_stim_fifo.sv - synchronous byte FIFO with full/empty flags and fill level
module uart_stim_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_stim_tx.sv
// rtl/uart_stim_tx.sv - buffered UART transmitter that drives a DUT serial receive line
module uart_stim_tx
  import uart_stim_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_valid,
  input  logic [7:0]                   wr_data,
  output logic                         wr_ready,
  output logic                         uart_txd,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         tx_done
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(CLKS_PER_BIT - 2);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    sr;
  logic          par_bit;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          bit_end;
  logic          last_stop;

  assign bit_end   = (baud_cnt == CNT_LAST);
  assign last_stop = (state == STOP) && (stop_idx == STOP_LAST);
  // Popping in the final stop cycle lets queued frames run back to back.
  assign pop       = !empty && ((state == IDLE) || (last_stop && bit_end));
  assign wr_ready  = !full;
  assign busy      = (state != IDLE) || (fifo_level != '0);

  uart_stim_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_valid && !full),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      sr       <= '0;
      par_bit  <= 1'b0;
      uart_txd <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      // Registered one cycle early so the pulse lands on the last stop cycle.
      tx_done <= last_stop && (baud_cnt == CNT_PRE);
      if (state != IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        IDLE: ;
        START: begin
          if (bit_end) begin
            state    <= DATA;
            bit_idx  <= '0;
            uart_txd <= sr[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              if (PARITY != PARITY_NONE) begin
                state    <= PAR;
                uart_txd <= par_bit;
              end else begin
                state    <= STOP;
                stop_idx <= 1'b0;
                uart_txd <= 1'b1;
              end
            end else begin
              sr       <= {1'b0, sr[7:1]};
              uart_txd <= sr[1];
              bit_idx  <= bit_idx + 1'b1;
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            state    <= STOP;
            stop_idx <= 1'b0;
            uart_txd <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_idx != STOP_LAST) stop_idx <= stop_idx + 1'b1;
            else                       state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          uart_txd <= 1'b1;
        end
      endcase

      if (pop) begin
        state    <= START;
        baud_cnt <= '0;
        sr       <= head;
        par_bit  <= (PARITY == PARITY_ODD) ? ~^head : ^head;
        uart_txd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// tb/tb_uart_stim_tx.sv - self-checking bench for uart_stim_tx with a frame-interval model and line monitors
module tb_uart_stim_tx;
  import uart_stim_pkg::*;

  localparam int NI   = 3;
  localparam int MAXF = 64;
  localparam int DEP  = 4;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       rdy  [NI];
  logic       txd  [NI];
  logic       bsy  [NI];
  logic [2:0] lvl  [NI];
  logic       done [NI];

  always #5 clock = ~clock;

  uart_stim_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEP), .PARITY(PARITY_NONE), .STOP_BITS(1)) u0 (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(rdy[0]),
    .uart_txd(txd[0]), .busy(bsy[0]), .fifo_level(lvl[0]), .tx_done(done[0]));
  uart_stim_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEP), .PARITY(PARITY_EVEN), .STOP_BITS(2)) u1 (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(rdy[1]),
    .uart_txd(txd[1]), .busy(bsy[1]), .fifo_level(lvl[1]), .tx_done(done[1]));
  uart_stim_tx #(.CLKS_PER_BIT(3), .FIFO_DEPTH(DEP), .PARITY(PARITY_ODD), .STOP_BITS(1)) u2 (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(rdy[2]),
    .uart_txd(txd[2]), .busy(bsy[2]), .fifo_level(lvl[2]), .tx_done(done[2]));

  function automatic int cpb(input int i);
    return (i == 2) ? 3 : 4;
  endfunction
  function automatic int par_of(input int i);
    return (i == 0) ? PARITY_NONE : ((i == 1) ? PARITY_EVEN : PARITY_ODD);
  endfunction
  function automatic int stops_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic int flen(input int i);
    return frame_len(par_of(i), stops_of(i)) * cpb(i);
  endfunction
  // Line level for serial bit k of a frame carrying byte b.
  function automatic logic exp_bit(input int i, input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && par_of(i) == PARITY_EVEN) return ^b;
    if (k == 9 && par_of(i) == PARITY_ODD) return ~^b;
    return 1'b1;
  endfunction

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0d, expected %0d (cycle %0d)", inst, nm, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Model: each accepted byte becomes a frame interval; outputs follow from the interval list.
  int         f_start [NI][MAXF];
  logic [7:0] f_byte  [NI][MAXF];
  int         nf [NI]       = '{0, 0, 0};
  logic       pend_v        = 1'b0;
  logic [7:0] pend_d        = 8'h00;
  logic       pend_rdy [NI] = '{1'b1, 1'b1, 1'b1};
  int         m_start, e_lvl;
  logic       e_busy, e_done, e_txd;

  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      if (reset && pend_v && pend_rdy[i] && nf[i] < MAXF) begin
        m_start = cyc + 1;
        if (nf[i] > 0 && f_start[i][nf[i]-1] + flen(i) > m_start) m_start = f_start[i][nf[i]-1] + flen(i);
        f_start[i][nf[i]] = m_start;
        f_byte[i][nf[i]]  = pend_d;
        nf[i]++;
      end
      if (!reset) nf[i] = 0;
      e_lvl = 0; e_busy = 1'b0; e_done = 1'b0; e_txd = 1'b1;
      for (int f = 0; f < nf[i]; f++) begin
        if (f_start[i][f] > cyc) e_lvl++;
        if (f_start[i][f] + flen(i) > cyc) e_busy = 1'b1;
        if (f_start[i][f] + flen(i) - 1 == cyc) e_done = 1'b1;
        if (f_start[i][f] <= cyc && cyc < f_start[i][f] + flen(i))
          e_txd = exp_bit(i, f_byte[i][f], (cyc - f_start[i][f]) / cpb(i));
      end
      check("uart_txd", i, txd[i], e_txd);
      check("fifo_level", i, lvl[i], e_lvl);
      check("busy", i, bsy[i], e_busy);
      check("tx_done", i, done[i], e_done);
      check("wr_ready", i, rdy[i], (e_lvl < DEP));
      pend_rdy[i] = (e_lvl < DEP);
    end
    pend_v = wr_valid && reset;
    pend_d = wr_data;
  end

  // Line monitors: decode each instance's serial output independently of the model.
  logic        rx_busy [NI] = '{1'b0, 1'b0, 1'b0};
  int          rx_s [NI];
  int          rx_k [NI];
  logic [15:0] rx_bits [NI];
  int          nrx [NI] = '{0, 0, 0};
  logic [7:0]  rx_byte  [NI][MAXF];
  logic        rx_par   [NI][MAXF];
  logic        rx_ok    [NI][MAXF];
  int          rx_start [NI][MAXF];
  int          nd [NI] = '{0, 0, 0};
  int          done_cyc [NI][MAXF];
  int          m_nb;
  logic        m_ok;

  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        rx_busy[i] = 1'b0;
      end else begin
        if (done[i] === 1'b1 && nd[i] < MAXF) begin
          done_cyc[i][nd[i]] = cyc;
          nd[i]++;
        end
        if (!rx_busy[i] && txd[i] === 1'b0) begin
          rx_busy[i] = 1'b1;
          rx_s[i]    = cyc;
          rx_k[i]    = 0;
        end
        if (rx_busy[i] && (cyc - rx_s[i]) == rx_k[i] * cpb(i) + cpb(i) / 2) begin
          rx_bits[i][rx_k[i]] = txd[i];
          rx_k[i]++;
          m_nb = frame_len(par_of(i), stops_of(i));
          if (rx_k[i] == m_nb) begin
            m_ok = !rx_bits[i][0];
            for (int s = m_nb - stops_of(i); s < m_nb; s++) m_ok = m_ok && rx_bits[i][s];
            if (nrx[i] < MAXF) begin
              rx_byte[i][nrx[i]]  = rx_bits[i][8:1];
              rx_par[i][nrx[i]]   = rx_bits[i][9];
              rx_ok[i][nrx[i]]    = m_ok;
              rx_start[i][nrx[i]] = rx_s[i];
              nrx[i]++;
            end
            rx_busy[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int g;
    g = 0;
    while (!rdy[0] && g < 3000) begin
      @(posedge clock); #1;
      g++;
    end
    check("send_ready_wait", 0, (g < 3000), 1);
    wr_valid = 1'b1;
    wr_data  = b;
    @(posedge clock); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((bsy[0] || bsy[1] || bsy[2]) && g < 3000) begin
      @(posedge clock); #1;
      g++;
    end
    check("idle_wait", 0, (g < 3000), 1);
    repeat (4) @(posedge clock);
    #1;
  endtask

  int b0, b1, b2, d0, d1, d2, acc, g;
  logic [7:0] ok_str [4];

  initial begin
    ok_str = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("reset_txd", i, txd[i], 1);
      check("reset_ready", i, rdy[i], 1);
      check("reset_busy", i, bsy[i], 0);
      check("reset_level", i, lvl[i], 0);
      check("reset_done", i, done[i], 0);
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Single byte 0x55
    b0 = nrx[0]; d0 = nd[0];
    send(8'h55);
    wait_idle();
    check("single_byte", 0, rx_byte[0][b0], 8'h55);
    check("single_frame_ok", 0, rx_ok[0][b0], 1);
    check("single_done_cycles", 0, done_cyc[0][d0] - rx_start[0][b0] + 1, 40);

    // Back-to-back 0xA5, 0x3C
    b0 = nrx[0]; d0 = nd[0];
    send(8'hA5);
    send(8'h3C);
    wait_idle();
    check("b2b_byte0", 0, rx_byte[0][b0], 8'hA5);
    check("b2b_byte1", 0, rx_byte[0][b0+1], 8'h3C);
    check("b2b_start_gap", 0, rx_start[0][b0+1] - rx_start[0][b0], 40);
    check("b2b_done_gap", 0, done_cyc[0][d0+1] - done_cyc[0][d0], 40);

    // FIFO full with depth 4
    b0 = nrx[0];
    acc = 0;
    wr_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr_data = 8'h10 + 8'(acc);
      if (rdy[0]) acc++;
      @(posedge clock); #1;
    end
    wr_valid = 1'b0;
    check("full_accepted", 0, acc, 5);
    check("full_ready_low", 0, rdy[0], 0);
    check("full_level", 0, lvl[0], 4);
    g = 0;
    while (lvl[0] == 3'd4 && g < 200) begin
      @(posedge clock); #1;
      g++;
    end
    check("full_pop_wait", 0, (g < 200), 1);
    check("full_level_after_pop", 0, lvl[0], 3);
    check("full_ready_after_pop", 0, rdy[0], 1);
    wait_idle();
    for (int k = 0; k < 5; k++) check("full_bytes", 0, rx_byte[0][b0+k], 8'h10 + k);

    // Parity and two stop bits
    b1 = nrx[1]; b2 = nrx[2]; d1 = nd[1]; d2 = nd[2];
    send(8'h07);
    send(8'h00);
    wait_idle();
    check("even_par_07", 1, rx_par[1][b1], 1);
    check("even_par_00", 1, rx_par[1][b1+1], 0);
    check("odd_par_07", 2, rx_par[2][b2], 0);
    check("odd_par_00", 2, rx_par[2][b2+1], 1);
    check("two_stop_frame_ok", 1, rx_ok[1][b1], 1);
    check("two_stop_done_cycles", 1, done_cyc[1][d1] - rx_start[1][b1] + 1, 48);
    check("odd_done_cycles", 2, done_cyc[2][d2] - rx_start[2][b2] + 1, 33);
    check("b2b_gap_two_stop", 1, rx_start[1][b1+1] - rx_start[1][b1], 48);

    // Reset in the middle of a data bit
    send(8'hFF);
    send(8'h00);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("abort_txd", i, txd[i], 1);
      check("abort_level", i, lvl[i], 0);
      check("abort_busy", i, bsy[i], 0);
      check("abort_ready", i, rdy[i], 1);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    b0 = nrx[0]; b2 = nrx[2];
    send(8'h5A);
    wait_idle();
    check("post_reset_byte", 0, rx_byte[0][b0], 8'h5A);
    check("post_reset_ok", 0, rx_ok[0][b0], 1);
    check("post_reset_byte", 2, rx_byte[2][b2], 8'h5A);

    // Loopback string "OK\r\n"
    b0 = nrx[0];
    for (int k = 0; k < 4; k++) send(ok_str[k]);
    wait_idle();
    check("loop_count", 0, nrx[0] - b0, 4);
    for (int k = 0; k < 4; k++) check("loop_char", 0, rx_byte[0][b0+k], ok_str[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
